// File: rtl/pipeline_stage_register_pkg.sv
// Shared definitions for the elastic pipeline stage registers: FSM encoding
// (the encoding doubles as the occupancy count) and the common bubble value.
package pipeline_stage_register_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int CTRL_NOP = 0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Elastic pipeline register with optional skid entry, bubble insertion on the
// control field, synchronous flush and a saturating back-pressure counter.
//
// Handshake: a beat moves on a side only in a cycle where valid and ready are
// both high at the rising edge; valid never depends on ready, and once out_valid
// is raised the presented beat stays stable until it is consumed.
module pipeline_stage_register
    import pipeline_stage_register_pkg::*;
#(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
    parameter int                SKID_EN     = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles,
    output pipe_state_t       dbg_state
);

    localparam bit HAS_SKID = (SKID_EN != 0);

    pipe_state_t       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    generate
        if (HAS_SKID) begin : g_skid
            // Pure state decode: no combinational path from out_ready to in_ready.
            assign in_ready = (state_q != ST_TWO);
        end else begin : g_single
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Data registers keep their contents; only validity is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (HAS_SKID && in_fire && !out_fire) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign dbg_state = state_q;

    pipe_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (out_valid && !out_ready),
        .count   (stall_cycles)
    );

endmodule
